// File: rtl/traffic_light_ctrl_n.sv
// rtl/traffic_light_ctrl_n.sv - N-road round-robin traffic light controller
// One road green at a time; min/max green, yellow, all-red clearance, emergency override.
module traffic_light_ctrl_n #(
    parameter int NUM_ROADS   = 4,
    parameter int CNT_W       = 8,
    parameter int GREEN_MIN   = 3,
    parameter int GREEN_MAX   = 6,
    parameter int YELLOW_TIME = 2,
    parameter int ALLRED_TIME = 1,
    parameter int IDX_W       = (NUM_ROADS > 1) ? $clog2(NUM_ROADS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_ROADS-1:0] req_i,
    input  logic                 emerg_en_i,
    input  logic [IDX_W-1:0]     emerg_road_i,
    output logic [NUM_ROADS-1:0] green_o,
    output logic [NUM_ROADS-1:0] yellow_o,
    output logic [NUM_ROADS-1:0] red_o,
    output logic [IDX_W-1:0]     active_road_o,
    output logic [1:0]           phase_o
);

    localparam logic [1:0] PH_ALLRED = 2'b00;
    localparam logic [1:0] PH_GREEN  = 2'b01;
    localparam logic [1:0] PH_YELLOW = 2'b10;

    localparam logic [CNT_W-1:0] AR_LAST    = CNT_W'(ALLRED_TIME - 1);
    localparam logic [CNT_W-1:0] G_MIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] G_MAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] Y_LAST     = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [NUM_ROADS-1:0] ROAD_ONE = NUM_ROADS'(1);

    logic [1:0]           phase_q,   phase_d;
    logic [CNT_W-1:0]     timer_q,   timer_d;
    logic [IDX_W-1:0]     active_q,  active_d;
    logic [NUM_ROADS-1:0] pending_q, pending_d;

    logic [NUM_ROADS-1:0] active_oh;
    logic [NUM_ROADS-1:0] eff;
    logic [NUM_ROADS-1:0] req_capture;
    logic [NUM_ROADS-1:0] grant_clr;
    logic                 emerg_valid;
    logic                 others_waiting;
    logic [IDX_W-1:0]     rr_sel;
    logic [IDX_W-1:0]     rr_idx;
    logic                 grant;
    logic [IDX_W-1:0]     grant_road;

    assign active_oh      = ROAD_ONE << active_q;
    assign eff            = pending_q | req_i;
    assign others_waiting = |(eff & ~active_oh);
    assign emerg_valid    = emerg_en_i && (32'(emerg_road_i) < 32'(NUM_ROADS));

    // Walk from the farthest candidate back to active+1 so the nearest hit wins.
    always_comb begin
        rr_sel = active_q;
        rr_idx = active_q;
        for (int k = NUM_ROADS; k >= 1; k--) begin
            rr_idx = IDX_W'((int'(active_q) + k) % NUM_ROADS);
            if (eff[rr_idx]) begin
                rr_sel = rr_idx;
            end
        end
    end

    always_comb begin
        phase_d    = phase_q;
        timer_d    = timer_q;
        active_d   = active_q;
        grant      = 1'b0;
        grant_road = rr_sel;
        grant_clr  = '0;

        case (phase_q)
            PH_ALLRED: begin
                if (timer_q == AR_LAST) begin
                    if (emerg_valid) begin
                        grant      = 1'b1;
                        grant_road = emerg_road_i;
                    end else if (|eff) begin
                        grant      = 1'b1;
                        grant_road = rr_sel;
                    end
                end else begin
                    timer_d = timer_q + CNT_ONE;
                end
            end
            PH_GREEN: begin
                if (emerg_valid && (emerg_road_i == active_q)) begin
                    timer_d = timer_q;
                end else if (emerg_valid || (timer_q == G_MAX_LAST) ||
                             ((timer_q >= G_MIN_LAST) && others_waiting)) begin
                    phase_d = PH_YELLOW;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_ONE;
                end
            end
            PH_YELLOW: begin
                if (timer_q == Y_LAST) begin
                    phase_d = PH_ALLRED;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_ONE;
                end
            end
            default: begin
                phase_d = PH_ALLRED;
                timer_d = '0;
            end
        endcase

        if (grant) begin
            phase_d   = PH_GREEN;
            timer_d   = '0;
            active_d  = grant_road;
            grant_clr = ROAD_ONE << grant_road;
        end
    end

    // The road being served cannot re-queue itself while it is green.
    assign req_capture = (phase_q == PH_GREEN) ? (req_i & ~active_oh) : req_i;
    assign pending_d   = (pending_q | req_capture) & ~grant_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q   <= PH_ALLRED;
            timer_q   <= '0;
            active_q  <= IDX_W'(NUM_ROADS - 1);
            pending_q <= '0;
        end else begin
            phase_q   <= phase_d;
            timer_q   <= timer_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    assign green_o       = (phase_q == PH_GREEN)  ? active_oh : '0;
    assign yellow_o      = (phase_q == PH_YELLOW) ? active_oh : '0;
    assign red_o         = ~(green_o | yellow_o);
    assign active_road_o = active_q;
    assign phase_o       = phase_q;

    a_single_lamp: assert property (@(posedge clk) disable iff (rst)
        $onehot0(green_o | yellow_o));
    a_yellow_then_red: assert property (@(posedge clk) disable iff (rst)
        (|yellow_o) |=> !(|green_o));
    a_phase_legal: assert property (@(posedge clk) disable iff (rst)
        phase_q != 2'b11);

endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// tb/tb_traffic_light_ctrl_n.sv - randomized and directed bench for traffic_light_ctrl_n
// Two instances (4 and 5 roads) share stimulus and are compared against a cycle-level reference model.
module tb_traffic_light_ctrl_n;

    localparam int ALLRED_TIME = 1;
    localparam int GREEN_MIN   = 3;
    localparam int GREEN_MAX   = 6;
    localparam int YELLOW_TIME = 2;

    logic       clk;
    logic       rst;
    logic [4:0] req;
    logic       emerg_en;
    logic [2:0] emerg_road;

    logic [3:0] g0, y0, r0;
    logic [1:0] a0, p0;
    logic [4:0] g1, y1, r1;
    logic [2:0] a1;
    logic [1:0] p1;

    int n_vec;
    int n_miss;

    int      m_ph[2];
    int      m_t[2];
    int      m_rd[2];
    bit [7:0] m_pd[2];
    int      nr[2] = '{4, 5};

    traffic_light_ctrl_n u0 (
        .clk(clk), .rst(rst), .req_i(req[3:0]), .emerg_en_i(emerg_en),
        .emerg_road_i(emerg_road[1:0]), .green_o(g0), .yellow_o(y0), .red_o(r0),
        .active_road_o(a0), .phase_o(p0)
    );

    traffic_light_ctrl_n #(.NUM_ROADS(5)) u1 (
        .clk(clk), .rst(rst), .req_i(req), .emerg_en_i(emerg_en),
        .emerg_road_i(emerg_road), .green_o(g1), .yellow_o(y1), .red_o(r1),
        .active_road_o(a1), .phase_o(p1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = 0;
            m_t[i]  = 0;
            m_rd[i] = nr[i] - 1;
            m_pd[i] = 8'd0;
        end
    endtask

    // Phases: 0 all-red, 1 green, 2 yellow; m_t counts cycles already spent in the phase.
    task automatic model_step(input int i);
        int       n, er, g;
        bit       ev;
        bit [7:0] rq, eff, np;
        n   = nr[i];
        rq  = 8'(req) & 8'((1 << n) - 1);
        er  = (i == 0) ? int'(emerg_road[1:0]) : int'(emerg_road);
        ev  = emerg_en && (er < n);
        eff = m_pd[i] | rq;
        np  = m_pd[i] | rq;
        if (m_ph[i] == 1) np[m_rd[i]] = m_pd[i][m_rd[i]];
        g = -1;
        if (m_ph[i] == 0) begin
            if (m_t[i] >= ALLRED_TIME - 1) begin
                if (ev) g = er;
                else
                    for (int k = 1; k <= n; k++)
                        if (g < 0 && eff[(m_rd[i] + k) % n]) g = (m_rd[i] + k) % n;
            end else begin
                m_t[i]++;
            end
        end else if (m_ph[i] == 1) begin
            if (ev && er == m_rd[i]) begin
                m_t[i] = m_t[i];
            end else if (ev || m_t[i] == GREEN_MAX - 1 ||
                         (m_t[i] >= GREEN_MIN - 1 && (eff & ~(8'd1 << m_rd[i])) != 8'd0)) begin
                m_ph[i] = 2;
                m_t[i]  = 0;
            end else begin
                m_t[i]++;
            end
        end else begin
            if (m_t[i] == YELLOW_TIME - 1) begin
                m_ph[i] = 0;
                m_t[i]  = 0;
            end else begin
                m_t[i]++;
            end
        end
        if (g >= 0) begin
            m_ph[i] = 1;
            m_rd[i] = g;
            m_t[i]  = 0;
            np[g]   = 1'b0;
        end
        m_pd[i] = np;
    endtask

    task automatic compare_all();
        bit [7:0] oh, eg, ey, er, mask;
        for (int i = 0; i < 2; i++) begin
            mask = 8'((1 << nr[i]) - 1);
            oh   = 8'd1 << m_rd[i];
            eg   = (m_ph[i] == 1) ? oh : 8'd0;
            ey   = (m_ph[i] == 2) ? oh : 8'd0;
            er   = ~(eg | ey) & mask;
            if (i == 0) begin
                chk("u0_green",  32'(g0), 32'(eg));
                chk("u0_yellow", 32'(y0), 32'(ey));
                chk("u0_red",    32'(r0), 32'(er));
                chk("u0_phase",  32'(p0), 32'(m_ph[0]));
                chk("u0_active", 32'(a0), 32'(m_rd[0]));
            end else begin
                chk("u1_green",  32'(g1), 32'(eg));
                chk("u1_yellow", 32'(y1), 32'(ey));
                chk("u1_red",    32'(r1), 32'(er));
                chk("u1_phase",  32'(p1), 32'(m_ph[1]));
                chk("u1_active", 32'(a1), 32'(m_rd[1]));
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst) begin
            model_step(0);
            model_step(1);
        end
        #1;
        compare_all();
    endtask

    task automatic wait_phase0(input logic [1:0] want, input string tag);
        int n;
        n = 0;
        while (p0 !== want && n < 50) begin
            cycle();
            n++;
        end
        chk(tag, 32'(p0), 32'(want));
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        #2;
        rst = 1'b0;
    endtask

    int grants[$];
    int rr_exp[3] = '{3, 0, 1};
    int n_green;
    logic [1:0] prev_p;

    initial begin
        n_vec = 0;
        n_miss = 0;
        rst = 1'b1;
        req = '0;
        emerg_en = 1'b0;
        emerg_road = '0;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        #2;
        rst = 1'b0;

        // Idle after reset: everything stays red.
        for (int c = 0; c < 20; c++) begin
            cycle();
            chk("idle_red", 32'(r0), 32'hf);
            chk("idle_phase", 32'(p0), 32'h0);
        end

        // Single pulse on road 2 runs the full max-green sequence.
        req = 5'b00100;
        cycle();
        req = '0;
        for (int j = 0; j < GREEN_MAX; j++) begin
            chk("pulse_green", 32'(g0), 32'h4);
            cycle();
        end
        for (int j = 0; j < YELLOW_TIME; j++) begin
            chk("pulse_yellow", 32'(y0), 32'h4);
            cycle();
        end
        chk("pulse_allred", 32'(p0), 32'h0);
        cycle();
        chk("pulse_rest", 32'(p0), 32'h0);

        // Early exit: road 0 green, road 1 requests during green cycle 1.
        req = 5'b00001;
        cycle();
        req = '0;
        chk("ee_g_t0", 32'(g0), 32'h1);
        cycle();
        chk("ee_g_t1", 32'(g0), 32'h1);
        req = 5'b00010;
        cycle();
        req = '0;
        chk("ee_g_t2", 32'(g0), 32'h1);
        cycle();
        chk("ee_y0", 32'(y0), 32'h1);
        cycle();
        chk("ee_y1", 32'(y0), 32'h1);
        cycle();
        chk("ee_allred", 32'(p0), 32'h0);
        cycle();
        chk("ee_next", 32'(g0), 32'h2);

        // Round-robin from active road 1 with roads 0, 1, 3 requesting in all-red.
        wait_phase0(2'b00, "rr_wait_allred");
        chk("rr_from", 32'(a0), 32'h1);
        req = 5'b01011;
        cycle();
        req = '0;
        prev_p = 2'b00;
        for (int j = 0; j < 60; j++) begin
            if (p0 == 2'b01 && prev_p != 2'b01) grants.push_back(int'(a0));
            prev_p = p0;
            cycle();
        end
        chk("rr_count", 32'(grants.size()), 32'd3);
        for (int j = 0; j < 3; j++)
            chk("rr_order", (j < grants.size()) ? 32'(grants[j]) : 32'hffff_ffff, 32'(rr_exp[j]));

        // Emergency for road 2 cuts road 0 short at timer 1.
        req = 5'b00001;
        cycle();
        req = '0;
        cycle();
        chk("em_g_t1", 32'(g0), 32'h1);
        emerg_en = 1'b1;
        emerg_road = 3'd2;
        cycle();
        chk("em_y0", 32'(y0), 32'h1);
        cycle();
        chk("em_y1", 32'(y0), 32'h1);
        cycle();
        chk("em_allred", 32'(p0), 32'h0);
        for (int j = 0; j < 12; j++) begin
            cycle();
            chk("em_hold", 32'(g0), 32'h4);
        end
        emerg_en = 1'b0;
        n_green = 0;
        while (g0 == 4'h4 && n_green < 20) begin
            n_green++;
            cycle();
        end
        chk("em_release_len", 32'(n_green), 32'(GREEN_MAX));

        // Road 5 is out of range for the 5-road instance and must be ignored there.
        emerg_en = 1'b1;
        emerg_road = 3'd5;
        for (int j = 0; j < 30; j++) begin
            req = (j % 7 == 0) ? 5'($urandom_range(0, 31)) : 5'd0;
            cycle();
            chk("inv_emerg_u1", 32'(a1 < 3'd5), 32'h1);
        end
        emerg_en = 1'b0;
        req = '0;
        for (int j = 0; j < 40; j++) cycle();

        // Reset in the middle of yellow with roads 1 and 3 pending.
        req = 5'b00001;
        cycle();
        req = 5'b01010;
        cycle();
        req = '0;
        wait_phase0(2'b10, "rst_wait_yellow");
        do_reset();
        chk("rst_red", 32'(r0), 32'hf);
        chk("rst_active", 32'(a0), 32'h3);
        for (int j = 0; j < 5; j++) begin
            cycle();
            chk("rst_pending_gone", 32'(p0), 32'h0);
        end
        req = 5'b00001;
        cycle();
        req = '0;
        chk("rst_first", 32'(g0), 32'h1);

        // Randomized traffic with emergency episodes and occasional resets.
        for (int c = 0; c < 2000; c++) begin
            req = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd0;
            if ($urandom_range(0, 29) == 0) emerg_en = ~emerg_en;
            if ($urandom_range(0, 15) == 0) emerg_road = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 499) == 0) do_reset();
            else cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
